// File: rtl/uart_controller.sv
// Memory-mapped UART: DATA/STATUS registers, 8N1 transmitter and receiver.
// TX and RX run independently; bus side effects only on mem_valid && mem_ready.
module uart_controller #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = '0;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [2:0]    tx_bit_q, tx_bit_d;

  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic          rx_s1_q, rx_s2_q;

  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic          is_write, sel_status, data_wr, tx_busy, hs;
  logic          data_wr_hs, data_rd_hs, stat_wr_hs;
  logic          rx_done, rx_ferr;
  logic          unused_bits;

  assign unused_bits = ^{mem_addr[31:3], mem_addr[1:0], mem_wdata[31:8]};

  assign is_write   = |mem_wstrb;
  assign sel_status = mem_addr[2];
  assign data_wr    = is_write && !sel_status;
  assign tx_busy    = (tx_state_q != S_IDLE);
  // Reset forces the idle view so the bus never stalls while reset is held.
  assign mem_ready  = !(data_wr && tx_busy && !reset);
  assign hs         = mem_valid && mem_ready && !reset;
  assign data_wr_hs = hs && data_wr;
  assign data_rd_hs = hs && !is_write && !sel_status;
  assign stat_wr_hs = hs && is_write && sel_status;

  assign mem_rdata = sel_status ? {28'b0, frame_err_q, overrun_q, rx_valid_q, tx_busy}
                                : {24'b0, rx_byte_q};

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    unique case (tx_state_q)
      S_IDLE: begin
        if (data_wr_hs) begin
          tx_state_d = S_START;
          tx_cnt_d   = RELOAD;
          tx_shift_d = mem_wdata[7:0];
          tx_bit_d   = 3'd0;
        end
      end
      S_START: begin
        if (tx_cnt_q == ZERO) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = RELOAD;
        end else begin
          tx_cnt_d = tx_cnt_q - ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == ZERO) begin
          tx_cnt_d   = RELOAD;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == ZERO) tx_state_d = S_IDLE;
        else tx_cnt_d = tx_cnt_q - ONE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign uart_tx = (tx_state_q == S_START) ? 1'b0 :
                   (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF;
        end
      end
      S_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (rx_cnt_q == ZERO) begin
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          rx_cnt_d   = RELOAD;
          rx_bit_d   = 3'd0;
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == ZERO) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = RELOAD;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == ZERO) begin
          rx_done    = rx_s2_q;
          rx_ferr    = !rx_s2_q;
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Setting a flag takes priority over a same-cycle clear.
  always_comb begin
    rx_byte_d   = rx_done ? rx_shift_q : rx_byte_q;
    rx_valid_d  = rx_done ? 1'b1 : (data_rd_hs ? 1'b0 : rx_valid_q);
    overrun_d   = (rx_done && rx_valid_q && !data_rd_hs) ? 1'b1 :
                  (stat_wr_hs && mem_wdata[2]) ? 1'b0 : overrun_q;
    frame_err_d = rx_ferr ? 1'b1 :
                  (stat_wr_hs && mem_wdata[3]) ? 1'b0 : frame_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_controller.sv
// Bench for uart_controller: frame-level model of TX waveform and register flags,
// checked every cycle, plus hand-computed literal expectations.
module tb_uart_controller;

  localparam int DIV = 25000000 / 115200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  uart_controller dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Completed RX frames posted by the stimulus, consumed by the model.
  logic [7:0] fr_byte [0:31];
  logic       fr_stop [0:31];
  int         fr_n = 0;
  int         fr_done = 0;

  // Literal expectations posted by the stimulus.
  int          lit_tx_base = -1;
  logic [9:0]  lit_tx_pat = '0;
  int          lit_hs_exp = -1;
  logic        lit_rd_on = 1'b0;
  logic [31:0] lit_rd = '0;

  // Model state.
  int          m_tx_start = -1;
  logic [7:0]  m_tx_byte = '0;
  logic [7:0]  m_byte = '0;
  logic        m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic        m_busy, m_tx, m_ready, is_wr, hs_m, prev_reset = 1'b0;
  logic [31:0] m_rd;
  int          k, off;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      m_busy = (m_tx_start >= 0) && (cyc > m_tx_start) && (cyc <= m_tx_start + 10 * DIV);
      m_tx = 1'b1;
      if (m_busy) begin
        k = (cyc - m_tx_start - 1) / DIV;
        if (k == 0) m_tx = 1'b0;
        else if (k <= 8) m_tx = m_tx_byte[k-1];
      end
      check("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx});
      is_wr = |mem_wstrb;
      m_ready = !(is_wr && !mem_addr[2] && m_busy && !reset);
      check("mem_ready", {31'b0, mem_ready}, {31'b0, m_ready});
      if (prev_reset) check("tx_idle_after_reset", {31'b0, uart_tx}, 32'd1);
      if (lit_tx_base >= 0 && cyc >= lit_tx_base) begin
        off = cyc - lit_tx_base;
        if (off % DIV == 0 && off / DIV < 10)
          check("tx_literal_bit", {31'b0, uart_tx}, {31'b0, lit_tx_pat[off/DIV]});
      end
      if (mem_valid && !reset && !is_wr) begin
        m_rd = mem_addr[2] ? {28'b0, m_ferr, m_ovr, m_valid, m_busy} : {24'b0, m_byte};
        check(mem_addr[2] ? "status_read" : "data_read", mem_rdata, m_rd);
        if (lit_rd_on) check("read_literal", mem_rdata, lit_rd);
      end
      hs_m = mem_valid && m_ready && !reset;
      if (reset) begin
        m_tx_start = -1;
        m_byte = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      end else begin
        if (hs_m && is_wr && !mem_addr[2]) begin
          if (lit_hs_exp >= 0) check("write_accept_cycle", cyc, lit_hs_exp);
          m_tx_start = cyc;
          m_tx_byte = mem_wdata[7:0];
        end
        if (hs_m && is_wr && mem_addr[2]) begin
          if (mem_wdata[2]) m_ovr = 1'b0;
          if (mem_wdata[3]) m_ferr = 1'b0;
        end
        if (hs_m && !is_wr && !mem_addr[2]) m_valid = 1'b0;
        if (fr_done < fr_n) begin
          if (fr_stop[fr_done]) begin
            if (m_valid) m_ovr = 1'b1;
            m_byte = fr_byte[fr_done];
            m_valid = 1'b1;
          end else begin
            m_ferr = 1'b1;
          end
          fr_done = fr_done + 1;
        end
      end
      prev_reset = reset;
    end
  end

  task automatic bus(input logic a2, input logic [3:0] st, input logic [31:0] wd,
                     output logic [31:0] rd, output int hs);
    int n;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = {29'b0, a2, 2'b0}; mem_wstrb = st; mem_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) break;
      n++;
      if (n > 5000) begin
        $display("FAIL bus_timeout: mem_ready stayed 0 for %0d cycles", n);
        $fatal(1, "bus handshake never completed");
      end
    end
    rd = mem_rdata; hs = cyc;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic rd_expect(input logic a2, input logic [31:0] exp);
    logic [31:0] rd; int hs;
    lit_rd = exp; lit_rd_on = 1'b1;
    bus(a2, 4'b0000, 32'h0, rd, hs);
    lit_rd_on = 1'b0;
    $display("read %s -> 0x%08h (expect 0x%08h)", a2 ? "STATUS" : "DATA", rd, exp);
  endtask

  task automatic wr(input logic a2, input logic [31:0] wd, output int hs);
    logic [31:0] rd;
    bus(a2, 4'b0001, wd, rd, hs);
    $display("write %s <- 0x%02h accepted at cycle %0d", a2 ? "STATUS" : "DATA", wd[7:0], hs);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    fr_byte[fr_n] = b; fr_stop[fr_n] = stop;
    fr_n = fr_n + 1;
    $display("rx frame 0x%02h stop=%0d driven", b, stop);
  endtask

  initial begin
    int hs1, hs2, hs;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd_expect(1'b1, 32'h0);

    // 0x55 frame: literal line pattern, then a second write 5 clocks later stalls.
    wr(1'b0, 32'h55, hs1);
    lit_tx_base = hs1 + 1; lit_tx_pat = 10'h2AA; lit_hs_exp = hs1 + 10 * DIV + 1;
    repeat (3) @(posedge clk);
    wr(1'b0, 32'hAA, hs2);
    lit_hs_exp = -1; lit_tx_base = -1;
    rd_expect(1'b1, 32'h1);
    repeat (10 * DIV + 20) @(posedge clk);

    // Concurrent TX and RX.
    wr(1'b0, 32'hC3, hs);
    rx_frame(8'hA3, 1'b1);
    rd_expect(1'b1, 32'h2);
    rd_expect(1'b0, 32'hA3);
    rd_expect(1'b1, 32'h0);

    // Overrun and its clear.
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    rd_expect(1'b1, 32'h6);
    rd_expect(1'b0, 32'h22);
    wr(1'b1, 32'h4, hs);
    rd_expect(1'b1, 32'h0);

    // Framing error, then a short glitch that must be ignored.
    rx_frame(8'h3C, 1'b0);
    repeat (300) @(posedge clk);
    rd_expect(1'b1, 32'h8);
    wr(1'b1, 32'h8, hs);
    rd_expect(1'b1, 32'h0);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (50) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (300) @(posedge clk);
    rd_expect(1'b1, 32'h0);
    rx_frame(8'h81, 1'b1);
    rd_expect(1'b1, 32'h2);
    rd_expect(1'b0, 32'h81);

    // Reset in the middle of a TX frame and an RX frame.
    wr(1'b0, 32'h0F, hs);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (4 * DIV + 100) @(posedge clk);
    #1 reset = 1'b1; uart_rx = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    $display("reset pulsed mid-frame at cycle %0d", cyc);
    repeat (10) @(posedge clk);
    rd_expect(1'b1, 32'h0);
    rx_frame(8'h5A, 1'b1);
    rd_expect(1'b1, 32'h2);
    rd_expect(1'b0, 32'h5A);
    wr(1'b0, 32'h81, hs);
    repeat (10 * DIV + 20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_controller.md
UART_CONTROLLER -- requirements
Module: uart_controller

Interface
REQ-001 Parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD (integer division, 217 at defaults) SHALL be the bit period in clocks.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-005 mem_valid  input  1  transfer request, already qualified by the top-level decode for 0xf0000000/0xf0000004.
REQ-006 mem_ready  output  1  transfer completes in any cycle with mem_valid && mem_ready.
REQ-007 mem_addr  input  32  only bit 2 used: 0 = DATA, 1 = STATUS.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_wstrb  input  4  nonzero = write, zero = read.
REQ-010 mem_rdata  output  32  read data, combinational from registers.
REQ-011 uart_tx  output  1  serial out, idle high.
REQ-012 uart_rx  input  1  serial in, asynchronous, idle high.

Function
REQ-013 Bus side effects SHALL occur only in handshake cycles (mem_valid && mem_ready); mem_valid low SHALL have no effect.
REQ-014 mem_ready SHALL be 1 for reads and STATUS writes; for DATA writes, mem_ready = !tx_busy (write stalls until transmitter idle).
REQ-015 DATA read: mem_rdata = {24'b0, rx_byte}; handshake clears rx_valid.
REQ-016 STATUS read: mem_rdata = {28'b0, frame_err, overrun, rx_valid, tx_busy} (bits 3..0).
REQ-017 STATUS write: wdata[2]=1 clears overrun, wdata[3]=1 clears frame_err; other bits ignored.
REQ-018 DATA write handshake: load wdata[7:0] into TX shift register, set tx_busy, TX FSM leaves IDLE.
REQ-019 TX FSM states IDLE, START, DATA, STOP; baud counter reloads DIV-1 on entry to each bit, bit advances when counter = 0.
REQ-020 TX timing: uart_tx low from the cycle after write handshake for DIV clocks (start), then 8 data bits LSB first, DIV clocks each, then high for DIV clocks (stop); total 10*DIV clocks.
REQ-021 tx_busy SHALL be 1 from the cycle after write handshake through the last stop-bit clock, then 0 in IDLE; back-to-back write accepted in the first IDLE cycle.
REQ-022 uart_rx SHALL pass through a 2-flop synchronizer (initialised high); RX logic uses the synchronized value only.
REQ-023 RX FSM states IDLE, START, DATA, STOP; IDLE -> START on synchronized 0, counter loaded DIV/2-1.
REQ-024 START at counter 0: line still 0 -> DATA (counter DIV-1); line 1 -> IDLE (glitch rejected, no flags).
REQ-025 DATA samples one bit per DIV clocks at mid-bit, shifts in LSB first, 8 bits -> STOP.
REQ-026 STOP sample at mid-bit: 1 -> rx_byte updated, rx_valid set; 0 -> frame_err set, rx_byte and rx_valid unchanged; both -> IDLE same cycle.
REQ-027 Byte completes while rx_valid=1 and no DATA-read handshake that cycle: rx_byte overwritten, overrun set, rx_valid stays 1.
REQ-028 Byte completes in same cycle as DATA-read handshake: read returns old byte, rx_byte takes new byte, rx_valid stays 1, no overrun.
REQ-029 Flag set and STATUS-write clear of the same flag in one cycle: set wins.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 On reset: uart_tx=1, tx_busy=0, rx_valid=0, overrun=0, frame_err=0, rx_byte=0, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-032 Reset mid-frame SHALL abort TX (uart_tx high next cycle) and RX (partial byte discarded, no flag).
REQ-033 During reset mem_ready SHALL follow REQ-014 with tx_busy=0; bus writes in reset cycles are ignored.

Verification
REQ-034 Write DATA 0x55 (wstrb 4'b0001) -> uart_tx start bit next cycle, pattern 0,1,0,1,0,1,0,1,0,1 each 217 clocks, tx_busy=1 for 2170 clocks.
REQ-035 Second DATA write 5 clocks after first -> mem_ready low until first frame's stop bit ends, accepted first IDLE cycle, no gap beyond one clock.
REQ-036 Drive 0xA3 at 115200 on uart_rx -> STATUS reads 0x2, DATA reads 0x000000A3, next STATUS reads 0x0.
REQ-037 Two bytes 0x11,0x22 without read -> STATUS 0x6, DATA 0x22; STATUS write 0x4 -> STATUS 0x0.
REQ-038 Frame with stop bit 0 -> STATUS 0x8, rx_valid 0; 50-clock low glitch on uart_rx -> no flags, FSM IDLE.
REQ-039 Assert reset mid TX and mid RX frame -> uart_tx=1 next cycle, STATUS 0x0, following full frame received correctly.
